uart_rx: RTL
============

# uart_rx

UART receiver, 8N1, LSB first. It recovers bytes from the serial line RX, validates start and stop bits, and presents each received byte on a one-byte holding register with a ready/acknowledge handshake. It pairs with the existing UART transmitter: same CLOCK/BAUD_RATE parameters, same line format, same idle-high line. It sits between the board RX pin and the echo/memory logic.

## Interface
- CLOCK, default 1_000_000: CLK frequency in Hz.
- BAUD_RATE, default 9_600: line rate in bit/s.
- Derived: BIT_CLKS = CLOCK/BAUD_RATE (integer division; 104 at defaults); HALF = BIT_CLKS/2 (52).
- Derived: counter width = $clog2(BIT_CLKS).
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- RX  input  1  asynchronous serial input; idle high.
- RD  input  1  read strobe; acknowledges the held byte when RXF=1.
- Q  output  8  last accepted byte.
- RXF  output  1  receive-full flag; 1 = Q holds an unread byte.
- FE  output  1  framing error; sticky.
- OE  output  1  overrun error; sticky.

## Operation
- RX passes through a 2-FF synchronizer (reset value 1); all decisions use the synchronized value rxs.
- Reset values: Q=8'h00, RXF=0, FE=0, OE=0, state=IDLE, counters=0, synchronizer=2'b11.
- State machine (IDLE, START, DATA, STOP, WAIT_IDLE); the cycle counter cnt restarts at 0 on every state entry.
  - IDLE: when rxs==0, go to START.
  - START: cnt counts up. At cnt==HALF-1, sample rxs. If 0, go to DATA with bit index 0. If 1 (glitch), return to IDLE with no flag change.
  - DATA: at cnt==BIT_CLKS-1, sample rxs into shreg[7] with a right shift, reset cnt, and increment the bit index. After the 8th sample, go to STOP.
  - STOP: at cnt==BIT_CLKS-1, sample rxs.
    - If 1: valid frame; update Q/RXF/OE per the handshake rules; FE<=0; go to IDLE.
    - If 0: set FE<=1; leave Q and RXF unchanged; go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs==1, then go to IDLE. This prevents a break or stuck-low line from retriggering.
- Handshake:
  - RD with RXF=1: RXF<=0 and OE<=0 on the next edge.
  - RD with RXF=0: ignored.
- Valid frame while RXF=1 and RD=0 (overrun): Q is kept, the new byte is discarded, OE<=1.
- Valid frame in the same cycle as RD with RXF=1: Q<=new byte, RXF stays 1, OE<=0.
- FE clears only on the next valid frame or on RST. OE clears only on an accepted RD or on RST.
- RST mid-frame: the frame is abandoned next edge; all outputs take reset values. A partial frame afterwards lands in IDLE/START and is handled by glitch rejection or WAIT_IDLE.

## Timing
- Sampling instants relative to the synchronized falling edge (rxs first 0 = cycle 0):
  - Start check at cycle HALF.
  - Data bit k at cycle HALF + (k+1)·BIT_CLKS.
  - Stop bit at HALF + 9·BIT_CLKS.
- RXF rises one cycle after the stop sample.
- Latency from the RX pin edge to RXF=1: 2 + HALF + 9·BIT_CLKS + 1 cycles (991 at defaults).
- A new start bit is accepted in the cycle after returning to IDLE. Back-to-back frames with one stop bit are received without loss.
- Outputs are registered; no combinational path from RX or RD to any output.
- Baud tolerance: mid-bit sampling tolerates about ±4% total rate mismatch.

## Test plan
- Reset: drive RST high for 3 cycles with RX=1 -> Q=00, RXF=FE=OE=0; state stays IDLE for 500 cycles.
- Single byte: send 0xA5 (104 clk/bit) -> RXF rises 991 cycles after the start edge, Q=A5, FE=0. Pulse RD -> RXF=0 next cycle.
- Back-to-back frames: send 0x00, 0xFF, 0x55 with no gap, reading each byte within 200 cycles of RXF -> Q sequence 00, FF, 55; OE=0.
- Overrun: send 0x12 and 0x34 with no RD -> Q=12, OE=1. Then RD -> RXF=0, OE=0. Then RD with a frame completing in the same cycle -> Q=new byte, RXF=1.
- Framing/glitch:
  - A 20-cycle low pulse on RX -> no state change.
  - Frame 0x3C with the stop bit held low for 300 cycles -> FE=1, RXF unchanged, no false start while the line is low.
  - A following good 0x3C -> FE=0, Q=3C.
- Reset mid-frame: assert RST at bit 4 of 0x81 -> RXF=0 and Q=00 next cycle. A following clean 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with mid-bit sampling and a one-byte holding
// register (Q/RXF) acknowledged by RD. Framing and overrun errors are sticky.
module uart_rx #(
  parameter int CLOCK     = 1_000_000,
  parameter int BAUD_RATE = 9_600
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  input  logic       RD,
  output logic [7:0] Q,
  output logic       RXF,
  output logic       FE,
  output logic       OE
);
  localparam int BIT_CLKS = CLOCK / BAUD_RATE;
  localparam int HALF     = BIT_CLKS / 2;
  localparam int CW       = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] CNT_BIT  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic [1:0]    sync;
  logic          rxs;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitidx;
  logic [7:0]    shreg;
  logic          cnt_bit;
  logic          frame_ok;
  logic          rd_ack;

  assign rxs      = sync[1];
  assign cnt_bit  = (cnt == CNT_BIT);
  assign frame_ok = (state == STOP) && cnt_bit && rxs;
  assign rd_ack   = RD && RXF;

  always_ff @(posedge CLK) begin
    if (RST) sync <= 2'b11;
    else     sync <= {sync[0], RX};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      bitidx <= '0;
      shreg  <= '0;
      Q      <= '0;
      RXF    <= 1'b0;
      FE     <= 1'b0;
      OE     <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt    <= '0;
            bitidx <= '0;
            state  <= rxs ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt_bit) begin
            cnt    <= '0;
            shreg  <= {rxs, shreg[7:1]};
            bitidx <= bitidx + 1'b1;
            if (bitidx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (cnt_bit) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              FE    <= 1'b1;
              state <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase

      // A frame landing together with an acknowledge replaces the held byte
      // and keeps RXF set; without the acknowledge it is an overrun.
      if (frame_ok) begin
        FE <= 1'b0;
        if (!RXF || RD) begin
          Q   <= shreg;
          RXF <= 1'b1;
          if (RXF) OE <= 1'b0;
        end else begin
          OE <= 1'b1;
        end
      end else if (rd_ack) begin
        RXF <= 1'b0;
        OE  <= 1'b0;
      end
    end
  end
endmodule
